// File: rtl/online_pkg.sv
// Shared types for online-arithmetic output stages: signed-digit encoding and converter FSM states.
// No logic; types and constants only.
// Digit {p,n}: 00 and 11 are zero, 10 is +1, 01 is -1.
package online_pkg;

  typedef struct packed {
    logic p;
    logic n;
  } sd_digit_t;

  localparam logic [1:0] SD_ZERO = 2'b00;
  localparam logic [1:0] SD_POS  = 2'b10;
  localparam logic [1:0] SD_NEG  = 2'b01;

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } otf_state_t;

endpackage

// File: rtl/otf_convert_step.sv
// One on-the-fly conversion step: appends a signed digit to the Q/QM pair (QM = Q-1 kept invariant).
// Latency: purely combinational.
// Backpressure: none; the caller decides whether to load the outputs.
module otf_convert_step
  import online_pkg::*;
#(
  parameter int W = 17
) (
  input  logic [W-1:0] q,
  input  logic [W-1:0] qm,
  input  sd_digit_t    digit,
  output logic [W-1:0] q_next,
  output logic [W-1:0] qm_next
);

  // Shift-and-append selection; the MSB falls off, which is safe because the
  // initial 0 / -1 values are already sign-extended across the full width.
  always_comb begin
    q_next  = q << 1;
    qm_next = (qm << 1) | W'(1);
    case ({digit.p, digit.n})
      SD_POS: begin
        q_next  = (q << 1) | W'(1);
        qm_next = q << 1;
      end
      SD_NEG: begin
        q_next  = (qm << 1) | W'(1);
        qm_next = qm << 1;
      end
      default: begin
        // 00 and 11 both count as a zero digit
        q_next  = q << 1;
        qm_next = (qm << 1) | W'(1);
      end
    endcase
  end

endmodule

// File: rtl/otf_sd_converter.sv
// On-the-fly signed-digit to two's-complement converter, one MSB-first digit per cycle.
// Latency: out_valid the cycle after the last digit is accepted; N_DIGITS+1 cycles/word at full rate.
// Backpressure: while a word is held (out_valid), in_ready is low and presented digits are ignored.
module otf_sd_converter
  import online_pkg::*;
#(
  parameter int N_DIGITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                dig_p,
  input  logic                dig_n,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N_DIGITS:0]   result
);

  localparam int W  = N_DIGITS + 1;
  localparam int CW = $clog2(N_DIGITS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N_DIGITS - 1);

  otf_state_t    state_q, state_d;
  logic [W-1:0]  q_q, q_d;
  logic [W-1:0]  qm_q, qm_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [W-1:0]  q_step;
  logic [W-1:0]  qm_step;
  sd_digit_t     digit;
  logic          dig_acc;

  assign digit = '{p: dig_p, n: dig_n};

  otf_convert_step #(
    .W (W)
  ) u_step (
    .q       (q_q),
    .qm      (qm_q),
    .digit   (digit),
    .q_next  (q_step),
    .qm_next (qm_step)
  );

  // Handshake flags decode straight from the state register.
  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == DONE);
  assign result    = q_q;
  assign dig_acc   = in_valid && in_ready;

  // Next-state: accumulate digits in ACC, hold the word in DONE until it is taken.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    qm_d    = qm_q;
    cnt_d   = cnt_q;
    case (state_q)
      ACC: begin
        if (dig_acc) begin
          q_d  = q_step;
          qm_d = qm_step;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          q_d     = '0;
          qm_d    = '1;
          state_d = ACC;
        end
      end
      default: begin
        state_d = ACC;
        q_d     = '0;
        qm_d    = '1;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers; reset overrides any handshake in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACC;
      q_q     <= '0;
      qm_q    <= '1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      qm_q    <= qm_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_otf_sd_converter.sv
// Directed and randomised checks of otf_sd_converter with N_DIGITS=4 (5-bit result).
// Inputs change 1 ns after the rising edge; outputs are sampled at that same point.
// Expected values come from hand-computed constants or a digit-sum model.
module tb_otf_sd_converter;

  localparam int N = 4;
  localparam int W = N + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         dig_p;
  logic         dig_n;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  otf_sd_converter #(
    .N_DIGITS (N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dig_p     (dig_p),
    .dig_n     (dig_n),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic int sd_val(input logic [1:0] code);
    if (code == 2'b10) return 1;
    if (code == 2'b01) return -1;
    return 0;
  endfunction

  // Present four digits at full rate, first digit in codes[7:6].
  task automatic feed(input logic [7:0] codes);
    logic [1:0] c;
    for (int i = 0; i < N; i++) begin
      c = codes[7-2*i -: 2];
      in_valid = 1'b1;
      {dig_p, dig_n} = c;
      step();
      if (i < N - 1) chk("ov_early", {31'd0, out_valid}, 32'd0);
    end
    in_valid = 1'b0;
    {dig_p, dig_n} = 2'b00;
  endtask

  // One complete word with out_ready high: check result, then the handshake.
  task automatic run_word(input string tag, input logic [7:0] codes, input logic [W-1:0] exp);
    out_ready = 1'b1;
    feed(codes);
    chk({tag, "_ov"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_res"}, {27'd0, result}, {27'd0, exp});
    chk({tag, "_ir_lo"}, {31'd0, in_ready}, 32'd0);
    step();
    chk({tag, "_ir_back"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_ov_drop"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    logic [1:0]   code;
    logic [W-1:0] e;
    logic [W-1:0] exp_q[$];
    int model, acc, pulses, last_pulse, guard;
    bit rdy;

    rst = 1'b1; in_valid = 1'b0; dig_p = 1'b0; dig_n = 1'b0; out_ready = 1'b1;
    step(); step();
    chk("rst_ov", {31'd0, out_valid}, 32'd0);
    chk("rst_ir", {31'd0, in_ready}, 32'd1);
    chk("rst_res", {27'd0, result}, 32'd0);
    rst = 1'b0;
    step();

    run_word("p000", 8'b10_00_00_00, 5'b01000);
    run_word("mp00", 8'b01_10_00_00, 5'b11100);
    run_word("pppp", 8'b10_10_10_10, 5'b01111);
    run_word("mmmm", 8'b01_01_01_01, 5'b10001);
    run_word("illegal11", 8'b11_10_11_01, 5'b00011);

    // Held word: consumer stalls three cycles while digits keep arriving.
    out_ready = 1'b0;
    feed(8'b10_01_00_10);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      {dig_p, dig_n} = 2'b10;
      step();
      chk("stall_ov", {31'd0, out_valid}, 32'd1);
      chk("stall_res", {27'd0, result}, 32'h05);
      chk("stall_ir", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("stall_release_ir", {31'd0, in_ready}, 32'd1);
    run_word("after_stall", 8'b00_00_01_10, 5'b11111);

    // Reset mid-word discards the partial word.
    in_valid = 1'b1;
    {dig_p, dig_n} = 2'b10;
    step(); step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_ov", {31'd0, out_valid}, 32'd0);
    chk("midrst_res", {27'd0, result}, 32'd0);
    run_word("after_rst", 8'b01_00_00_10, 5'b11001);

    // Reset while a word is held and out_ready is high.
    feed(8'b10_10_10_10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("donerst_ov", {31'd0, out_valid}, 32'd0);
    chk("donerst_res", {27'd0, result}, 32'd0);
    chk("donerst_ir", {31'd0, in_ready}, 32'd1);

    // Random words with bubbles and occasional consumer stalls.
    for (int w = 0; w < 1000; w++) begin
      model = 0;
      for (int i = 0; i < N; i++) begin
        while ($urandom_range(0, 2) == 0) begin
          in_valid = 1'b0;
          {dig_p, dig_n} = 2'($urandom_range(0, 3));
          step();
        end
        code = 2'($urandom_range(0, 3));
        in_valid = 1'b1;
        {dig_p, dig_n} = code;
        model += sd_val(code) * (1 << (N - 1 - i));
        step();
      end
      in_valid = 1'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      e = model[W-1:0];
      chk("rnd_ov", {31'd0, out_valid}, 32'd1);
      chk("rnd_res", {27'd0, result}, {27'd0, e});
      while (!out_ready) begin
        step();
        chk("rnd_hold", {27'd0, result}, {27'd0, e});
        out_ready = ($urandom_range(0, 1) != 0);
      end
      in_valid = $urandom_range(0, 1);
      step();
      chk("rnd_ir", {31'd0, in_ready}, 32'd1);
    end

    // Back-to-back words at full rate: one pulse per word, N+1 cycles apart.
    out_ready = 1'b1;
    in_valid = 1'b0;
    step();
    acc = 0; model = 0; pulses = 0; last_pulse = -1; guard = 0;
    while (acc < 5 * N && guard < 200) begin
      guard++;
      code = 2'($urandom_range(0, 3));
      in_valid = 1'b1;
      {dig_p, dig_n} = code;
      rdy = in_ready;
      step();
      if (rdy) begin
        model += sd_val(code) * (1 << (N - 1 - (acc % N)));
        acc++;
        if (acc % N == 0) begin
          exp_q.push_back(model[W-1:0]);
          model = 0;
        end
      end
      if (out_valid) begin
        pulses++;
        if (exp_q.size() == 0) chk("b2b_spurious", 32'd1, 32'd0);
        else chk("b2b_res", {27'd0, result}, {27'd0, exp_q.pop_front()});
        if (last_pulse >= 0) chk("b2b_gap", cyc - last_pulse, N + 1);
        last_pulse = cyc;
      end
    end
    in_valid = 1'b0;
    step();
    chk("b2b_digits", acc, 5 * N);
    chk("b2b_pulses", pulses, 5);
    chk("b2b_idle_ov", {31'd0, out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
